// File: rtl/lpc_stream_pkg.sv
// Shared types and constants for the LPC stream masters.
`timescale 1ns/1ps
package lpc_stream_pkg;

  localparam int SAMPLE_W         = 16;
  localparam int BYTES_PER_SAMPLE = 2;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/lpc_wm_fifo.sv
// Synchronous sample FIFO with a registered read port; rd_data updates on pop.
`timescale 1ns/1ps
module lpc_wm_fifo
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LVL_W'(DEPTH));
  assign empty   = (level == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // NOTE: the storage array has no reset; only pointers and the read register need a defined state.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      rd_data <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop) begin
        rd_ptr  <= rd_ptr + PTR_W'(1);
        rd_data <= mem[rd_ptr];
      end
      case ({do_push, do_pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/lpc_write_master_stream.sv
// Strobe-qualified sample capture into a FIFO, drained by an Avalon-MM write master.
// Optional LPC_WM_DROP_COUNT_EN adds a saturating drop_count output.
`timescale 1ns/1ps
module lpc_write_master_stream
  import lpc_stream_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_W     = 32,
  parameter int LEN_W      = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [SAMPLE_W-1:0] d_in,
  input  logic                v,
  input  logic                d_in_clk,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [LEN_W-1:0]    length,
  output logic                busy,
  output logic                done,
  output logic                overflow,
`ifdef LPC_WM_DROP_COUNT_EN
  output logic [15:0]         drop_count,
`endif
  output logic [ADDR_W-1:0]   avm_address,
  output logic                avm_write,
  output logic [SAMPLE_W-1:0] avm_writedata,
  output logic [1:0]          avm_byteenable,
  input  logic                avm_waitrequest
);

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  state_t              state, state_next;
  logic                d_in_clk_q;
  logic                strobe_edge;
  logic                start_ok;
  logic                push_req, push, pop, drop;
  logic                wr_done, last_write;
  logic                zero_done;
  logic                fifo_full, fifo_empty;
  logic [LVL_W-1:0]    unused_fifo_level;
  logic [SAMPLE_W-1:0] fifo_rd_data;
  logic [LEN_W-1:0]    length_q, accepted_cnt, written_cnt;
  logic [ADDR_W-1:0]   next_addr;

  assign avm_byteenable = 2'b11;
  assign avm_writedata  = fifo_rd_data;

  assign strobe_edge = d_in_clk & ~d_in_clk_q;
  assign start_ok    = start & (state == IDLE);
  // Once length samples are accepted, further strobes are simply ignored (not drops).
  assign push_req    = strobe_edge & v & (state == RUN) & (accepted_cnt != length_q);
  assign pop         = (state == RUN) & ~fifo_empty & (~avm_write | ~avm_waitrequest);
  assign push        = push_req & (~fifo_full | pop);
  assign drop        = push_req & fifo_full & ~pop;
  assign wr_done     = avm_write & ~avm_waitrequest;
  assign last_write  = wr_done & ((written_cnt + LEN_W'(1)) == length_q);

  lpc_wm_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (SAMPLE_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .pop     (pop),
    .wr_data (d_in),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (unused_fifo_level)
  );

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: every output of this block is defaulted first so no path infers a latch.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = zero_done;
    case (state)
      IDLE: if (start && length != '0) state_next = RUN;
      RUN: begin
        busy = 1'b1;
        if (last_write) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d_in_clk_q   <= 1'b0;
      zero_done    <= 1'b0;
      length_q     <= '0;
      accepted_cnt <= '0;
      written_cnt  <= '0;
      next_addr    <= '0;
      overflow     <= 1'b0;
      avm_write    <= 1'b0;
      avm_address  <= '0;
    end else begin
      d_in_clk_q <= d_in_clk;
      zero_done  <= start_ok & (length == '0);
      if (start_ok) begin
        length_q     <= length;
        next_addr    <= base_addr & ~ADDR_W'(1);
        accepted_cnt <= '0;
        written_cnt  <= '0;
        overflow     <= 1'b0;
      end else begin
        if (push)    accepted_cnt <= accepted_cnt + LEN_W'(1);
        if (drop)    overflow     <= 1'b1;
        if (wr_done) written_cnt  <= written_cnt + LEN_W'(1);
      end
      // A pop refills the output register in the same cycle the previous write completes.
      if (pop) begin
        avm_write   <= 1'b1;
        avm_address <= next_addr;
        next_addr   <= next_addr + ADDR_W'(BYTES_PER_SAMPLE);
      end else if (wr_done) begin
        avm_write <= 1'b0;
      end
    end
  end

`ifdef LPC_WM_DROP_COUNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                               drop_count <= '0;
    else if (start_ok)                       drop_count <= '0;
    else if (drop && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
  end
`else
  // Without the counter, drops are reported only through the sticky overflow flag.
`endif

endmodule

// File: tb/tb_lpc_write_master_stream.sv
// Directed self-checking bench for lpc_write_master_stream; honours LPC_WM_DROP_COUNT_EN.
`timescale 1ns/1ps
module tb_lpc_write_master_stream;

  logic        clk;
  logic        reset;
  logic [15:0] d_in;
  logic        v;
  logic        d_in_clk;
  logic        start;
  logic [31:0] base_addr;
  logic [15:0] length;
  logic        busy;
  logic        done;
  logic        overflow;
`ifdef LPC_WM_DROP_COUNT_EN
  logic [15:0] drop_count;
`endif
  logic [31:0] avm_address;
  logic        avm_write;
  logic [15:0] avm_writedata;
  logic [1:0]  avm_byteenable;
  logic        avm_waitrequest;

  int checks = 0;
  int errors = 0;

  logic [31:0] wa[$];
  logic [15:0] wd[$];
  int          done_cnt  = 0;
  int          hold_errs = 0;
  logic        stall_prev = 1'b0;
  logic [31:0] stall_addr;
  logic [15:0] stall_data;

  lpc_write_master_stream dut (
    .clk             (clk),
    .reset           (reset),
    .d_in            (d_in),
    .v               (v),
    .d_in_clk        (d_in_clk),
    .start           (start),
    .base_addr       (base_addr),
    .length          (length),
    .busy            (busy),
    .done            (done),
    .overflow        (overflow),
`ifdef LPC_WM_DROP_COUNT_EN
    .drop_count      (drop_count),
`endif
    .avm_address     (avm_address),
    .avm_write       (avm_write),
    .avm_writedata   (avm_writedata),
    .avm_byteenable  (avm_byteenable),
    .avm_waitrequest (avm_waitrequest)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Bus monitor: records completed writes, done pulses and stall-hold violations.
  always @(negedge clk) begin
    if (reset) begin
      stall_prev = 1'b0;
    end else begin
      if (avm_write && !avm_waitrequest) begin
        wa.push_back(avm_address);
        wd.push_back(avm_writedata);
      end
      if (done) done_cnt++;
      if (stall_prev && !(avm_write && avm_address == stall_addr && avm_writedata == stall_data))
        hold_errs++;
      stall_prev = avm_write && avm_waitrequest;
      stall_addr = avm_address;
      stall_data = avm_writedata;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic start_xfer(input logic [31:0] b, input logic [15:0] n);
    next_cycle();
    start     = 1'b1;
    base_addr = b;
    length    = n;
    next_cycle();
    start     = 1'b0;
  endtask

  task automatic pulse(input logic [15:0] data, input logic vv);
    next_cycle();
    d_in     = data;
    v        = vv;
    d_in_clk = 1'b1;
    next_cycle();
    d_in_clk = 1'b0;
    v        = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int max);
    int n = 0;
    while (busy && n < max) begin
      next_cycle();
      n++;
    end
    check(tag, busy, 1'b0);
    repeat (2) next_cycle();
  endtask

  task automatic clear_log();
    wa.delete();
    wd.delete();
    done_cnt  = 0;
    hold_errs = 0;
  endtask

  initial begin
    reset = 1'b1; d_in = '0; v = 1'b0; d_in_clk = 1'b0; start = 1'b0;
    base_addr = '0; length = '0; avm_waitrequest = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_ovf", overflow, 1'b0);
    check("rst_write", avm_write, 1'b0);
    check("rst_addr", avm_address, 32'h0);
    check("rst_data", avm_writedata, 16'h0);
    check("byteenable", avm_byteenable, 2'b11);
    reset = 1'b0;

    // Basic transfer with latency check on the first sample.
    clear_log();
    start_xfer(32'h1000, 16'd4);
    check("t1_busy", busy, 1'b1);
    next_cycle();
    d_in = 16'd1; v = 1'b1; d_in_clk = 1'b1;
    next_cycle();
    d_in_clk = 1'b0; v = 1'b0;
    check("t1_lat_n1", avm_write, 1'b0);
    next_cycle();
    check("t1_lat_n2", avm_write, 1'b1);
    check("t1_lat_addr", avm_address, 32'h1000);
    check("t1_lat_data", avm_writedata, 16'd1);
    for (int i = 2; i <= 4; i++) pulse(16'(i), 1'b1);
    wait_idle("t1_idle", 50);
    check("t1_count", wa.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t1_addr%0d", i), wa[i], 32'h1000 + 32'(2 * i));
      check($sformatf("t1_data%0d", i), wd[i], 16'(i + 1));
    end
    check("t1_done_cnt", done_cnt, 1);

    // Second write stalled for three cycles.
    clear_log();
    start_xfer(32'h1000, 16'd4);
    pulse(16'd1, 1'b1);
    repeat (2) next_cycle();
    avm_waitrequest = 1'b1;
    pulse(16'd2, 1'b1);
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      check($sformatf("t2_stall_w%0d", k), avm_write, 1'b1);
      check($sformatf("t2_stall_a%0d", k), avm_address, 32'h1002);
      check($sformatf("t2_stall_d%0d", k), avm_writedata, 16'd2);
    end
    next_cycle();
    avm_waitrequest = 1'b0;
    pulse(16'd3, 1'b1);
    pulse(16'd4, 1'b1);
    wait_idle("t2_idle", 50);
    check("t2_count", wa.size(), 4);
    check("t2_addr1", wa[1], 32'h1002);
    check("t2_data1", wd[1], 16'd2);
    check("t2_data2", wd[2], 16'd3);
    check("t2_hold", hold_errs, 0);
    check("t2_done_cnt", done_cnt, 1);

    // Overflow: one sample parked on the bus plus FIFO_DEPTH in the FIFO, 3 of 20 dropped.
    clear_log();
    avm_waitrequest = 1'b1;
    start_xfer(32'h2000, 16'd40);
    for (int i = 1; i <= 20; i++) pulse(16'(i), 1'b1);
    check("t3_ovf", overflow, 1'b1);
    check("t3_busy", busy, 1'b1);
    check("t3_none", wa.size(), 0);
    check("t3_head_addr", avm_address, 32'h2000);
    check("t3_head_data", avm_writedata, 16'd1);
`ifdef LPC_WM_DROP_COUNT_EN
    check("t3_drop_count", drop_count, 16'd3);
`endif
    avm_waitrequest = 1'b0;
    repeat (20) next_cycle();
    check("t3_drained", wa.size(), 17);
    check("t3_last_kept", wd[16], 16'd17);
    check("t3_still_busy", busy, 1'b1);
    for (int k = 0; k < 23; k++) pulse(16'(100 + k), 1'b1);
    wait_idle("t3_idle", 50);
    check("t3_count", wa.size(), 40);
    check("t3_data17", wd[17], 16'd100);
    check("t3_addr39", wa[39], 32'h204E);
    check("t3_data39", wd[39], 16'd122);
    check("t3_ovf_sticky", overflow, 1'b1);
    check("t3_done_cnt", done_cnt, 1);

    // Zero-length start, then a start issued while busy.
    clear_log();
    start_xfer(32'h0, 16'd0);
    check("t4_done", done, 1'b1);
    check("t4_busy", busy, 1'b0);
    check("t4_ovf_clr", overflow, 1'b0);
`ifdef LPC_WM_DROP_COUNT_EN
    check("t4_drop_clr", drop_count, 16'd0);
`endif
    next_cycle();
    check("t4_done_end", done, 1'b0);
    check("t4_no_write", wa.size(), 0);
    done_cnt = 0;
    start_xfer(32'h3000, 16'd2);
    start_xfer(32'h5000, 16'd5);
    pulse(16'h0011, 1'b1);
    pulse(16'h0022, 1'b1);
    wait_idle("t4_idle", 50);
    check("t4_count", wa.size(), 2);
    check("t4_addr0", wa[0], 32'h3000);
    check("t4_addr1", wa[1], 32'h3002);
    check("t4_data1", wd[1], 16'h0022);
    check("t4_done_cnt", done_cnt, 1);

    // v=0 edge, held strobe level, and address wrap.
    clear_log();
    start_xfer(32'hFFFF_FFFE, 16'd2);
    next_cycle();
    d_in = 16'hAAAA; v = 1'b0; d_in_clk = 1'b1;
    next_cycle();
    v = 1'b1;
    repeat (3) next_cycle();
    d_in_clk = 1'b0; v = 1'b0;
    repeat (3) next_cycle();
    check("t5_nopush", wa.size(), 0);
    check("t5_nowrite", avm_write, 1'b0);
    pulse(16'h8001, 1'b1);
    pulse(16'h7FFF, 1'b1);
    wait_idle("t5_idle", 50);
    check("t5_count", wa.size(), 2);
    check("t5_addr0", wa[0], 32'hFFFF_FFFE);
    check("t5_addr1", wa[1], 32'h0000_0000);
    check("t5_data0", wd[0], 16'h8001);
    check("t5_data1", wd[1], 16'h7FFF);

    // Reset in the middle of a stalled transfer, then a fresh run.
    clear_log();
    avm_waitrequest = 1'b1;
    start_xfer(32'h4000, 16'd4);
    pulse(16'h00A1, 1'b1);
    pulse(16'h00A2, 1'b1);
    next_cycle();
    check("t6_stall", avm_write, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check("t6_rst_write", avm_write, 1'b0);
    check("t6_rst_busy", busy, 1'b0);
    check("t6_rst_done", done, 1'b0);
    next_cycle();
    reset = 1'b0;
    avm_waitrequest = 1'b0;
    repeat (4) next_cycle();
    check("t6_no_done", done_cnt, 0);
    check("t6_no_write", wa.size(), 0);
    start_xfer(32'h4100, 16'd1);
    pulse(16'h0055, 1'b1);
    wait_idle("t6_idle", 50);
    check("t6_count", wa.size(), 1);
    check("t6_addr0", wa[0], 32'h4100);
    check("t6_data0", wd[0], 16'h0055);
    check("t6_done_cnt", done_cnt, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
